// File: rtl/raycaster_pkg.sv
// Shared raycaster types: screen defaults, column field widths and the
// packed DDA-out column word used by both the transmitter and unpacker.
package raycaster_pkg;

   localparam int SCREEN_WIDTH_DEF  = 320;
   localparam int SCREEN_HEIGHT_DEF = 240;

   localparam int HCOUNT_W = 9;
   localparam int LHEIGHT_W = 8;
   localparam int WTYPE_W = 1;
   localparam int MAP_W = 4;
   localparam int WALLX_W = 16;

   localparam int COL_W =
      HCOUNT_W + LHEIGHT_W + WTYPE_W + MAP_W + WALLX_W;

   typedef struct packed {
      logic [HCOUNT_W-1:0]  hcount;
      logic [LHEIGHT_W-1:0] line_height;
      logic [WTYPE_W-1:0]   wall_type;
      logic [MAP_W-1:0]     map_data;
      logic [WALLX_W-1:0]   wallX;
   } dda_col_t;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_ONE   = 2'd1,
      SB_TWO   = 2'd2
   } sb_state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered ready/valid, full throughput,
// output word held stable while stalled.
module skid_buffer
   import raycaster_pkg::*;
#(
   parameter int W = 39
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic         in_ready_o,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   input  logic         out_ready_i
);

   sb_state_e    state_q, state_d;
   logic [W-1:0] main_q, skid_q;
   logic         ready_q, valid_q;
   logic         in_acc, out_acc;

   assign in_acc  = in_valid_i & ready_q;
   assign out_acc = valid_q & out_ready_i;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SB_EMPTY: if (in_acc) state_d = SB_ONE;
         SB_ONE: begin
            if (in_acc && !out_acc)      state_d = SB_TWO;
            else if (!in_acc && out_acc) state_d = SB_EMPTY;
         end
         SB_TWO: if (out_acc) state_d = SB_ONE;
         default: state_d = SB_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SB_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != SB_TWO);
         valid_q <= (state_d != SB_EMPTY);
         unique case (state_q)
            SB_EMPTY: if (in_acc) main_q <= in_data_i;
            SB_ONE: begin
               // With no drain the new word parks in the skid entry.
               if (in_acc && out_acc) main_q <= in_data_i;
               else if (in_acc)       skid_q <= in_data_i;
            end
            SB_TWO: if (out_acc) main_q <= skid_q;
            default: ;
         endcase
      end
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = main_q;

endmodule

// File: rtl/dda_out_tx.sv
// DDA-out column transmitter: saturate, pack, drop out-of-range columns.
// Optional column-order checker enabled by DDA_OUT_TX_SEQCHK_EN.
module dda_out_tx
   import raycaster_pkg::*;
#(
   parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
   parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
   input  logic          pixel_clk_in,
   input  logic          rst_in,
   input  logic          hit_valid_in,
   output logic          hit_ready_out,
   input  logic [8:0]    hit_hcount_in,
   input  logic [15:0]   hit_line_height_in,
   input  logic          hit_wall_type_in,
   input  logic [3:0]    hit_map_data_in,
   input  logic [15:0]   hit_wallX_in,
   input  logic          dda_fsm_out_tready,
   output logic          dda_fsm_out_tvalid,
   output logic [37:0]   dda_fsm_out_tdata,
   output logic          dda_fsm_out_tlast,
   output logic [7:0]    frames_sent_out,
   output logic          seq_err_out
);

   dda_col_t          col;
   logic              in_range, is_last;
   logic [COL_W:0]    sb_in, sb_out;
   logic [7:0]        frames_q;

   assign in_range = 32'(hit_hcount_in) < 32'(SCREEN_WIDTH);
   assign is_last  = hit_hcount_in == 9'(SCREEN_WIDTH - 1);

   always_comb begin
      col.hcount   = hit_hcount_in;
      col.line_height =
         (hit_line_height_in > 16'(SCREEN_HEIGHT)) ?
         8'(SCREEN_HEIGHT) : hit_line_height_in[7:0];
      col.wall_type = hit_wall_type_in;
      col.map_data = hit_map_data_in;
      col.wallX    = hit_wallX_in;
   end

   assign sb_in = {is_last, col};

   // Out-of-range columns see a ready, but never enter the buffer.
   skid_buffer #(.W(COL_W + 1)) u_skid (
      .clk_i       (pixel_clk_in),
      .rst_i       (rst_in),
      .in_valid_i  (hit_valid_in & in_range),
      .in_data_i   (sb_in),
      .in_ready_o  (hit_ready_out),
      .out_valid_o (dda_fsm_out_tvalid),
      .out_data_o  (sb_out),
      .out_ready_i (dda_fsm_out_tready)
   );

   assign dda_fsm_out_tdata = sb_out[COL_W-1:0];
   assign dda_fsm_out_tlast = sb_out[COL_W];

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in)
         frames_q <= '0;
      else if (dda_fsm_out_tvalid && dda_fsm_out_tready
               && sb_out[COL_W])
         frames_q <= frames_q + 8'd1;
   end

   assign frames_sent_out = frames_q;

`ifdef DDA_OUT_TX_SEQCHK_EN
   logic [8:0] exp_q;
   logic       err_q;
   logic       hit_acc;

   assign hit_acc = hit_valid_in & hit_ready_out;

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         exp_q <= '0;
         err_q <= 1'b0;
      end else if (hit_acc) begin
         if (!in_range || hit_hcount_in != exp_q)
            err_q <= 1'b1;
         if (in_range)
            exp_q <= is_last ? 9'd0 : hit_hcount_in + 9'd1;
      end
   end

   assign seq_err_out = err_q;
`else
   assign seq_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_dda_out_tx.sv
// Directed bench for dda_out_tx: vector table plus multi-cycle sequences.
module tb_dda_out_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hv = 1'b0;
   logic        hrdy;
   logic [8:0]  hh = '0;
   logic [15:0] hlh = '0;
   logic        hw = 1'b0;
   logic [3:0]  hm = '0;
   logic [15:0] hx = '0;
   logic        trdy = 1'b0;
   logic        tv;
   logic [37:0] td;
   logic        tl;
   logic [7:0]  fr;
   logic        serr;

   int n_pass = 0;
   int n_tot = 0;

`ifdef DDA_OUT_TX_SEQCHK_EN
   localparam logic SEQ_ON = 1'b1;
`else
   localparam logic SEQ_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   dda_out_tx dut (
      .pixel_clk_in       (clk),
      .rst_in             (rst),
      .hit_valid_in       (hv),
      .hit_ready_out      (hrdy),
      .hit_hcount_in      (hh),
      .hit_line_height_in (hlh),
      .hit_wall_type_in   (hw),
      .hit_map_data_in    (hm),
      .hit_wallX_in       (hx),
      .dda_fsm_out_tready (trdy),
      .dda_fsm_out_tvalid (tv),
      .dda_fsm_out_tdata  (td),
      .dda_fsm_out_tlast  (tl),
      .frames_sent_out    (fr),
      .seq_err_out        (serr)
   );

   typedef struct {
      logic [8:0]  h;
      logic [15:0] lh;
      logic        w;
      logic [3:0]  m;
      logic [15:0] x;
      logic        e_v;
      logic [7:0]  e_lh;
      logic        e_last;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hv = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic col(input logic [8:0] h);
      hv = 1'b1;
      hh = h;
      hlh = 16'd10;
      hw = 1'b0;
      hm = 4'd1;
      hx = 16'h0;
   endtask

   initial begin
      logic [37:0] ew;
      int bad_h, bad_l, bad_v;

      vecs[0] = '{9'd5,   16'd100,   1'b1, 4'd3, 16'h8000,
                  1'b1, 8'd100, 1'b0};
      vecs[1] = '{9'd6,   16'h0300,  1'b0, 4'd2, 16'h1234,
                  1'b1, 8'd240, 1'b0};
      vecs[2] = '{9'd7,   16'd239,   1'b1, 4'd15, 16'hFFFF,
                  1'b1, 8'd239, 1'b0};
      vecs[3] = '{9'd8,   16'd240,   1'b0, 4'd0, 16'h0001,
                  1'b1, 8'd240, 1'b0};
      vecs[4] = '{9'd9,   16'd241,   1'b1, 4'd9, 16'hABCD,
                  1'b1, 8'd240, 1'b0};
      vecs[5] = '{9'd319, 16'd50,    1'b0, 4'd7, 16'h00F0,
                  1'b1, 8'd50, 1'b1};
      vecs[6] = '{9'd400, 16'd20,    1'b0, 4'd1, 16'h0000,
                  1'b0, 8'd20, 1'b0};

      rst = 1'b1;
      tick();
      chk("rst_ready", hrdy, 0);
      chk("rst_tvalid", tv, 0);
      chk("rst_tdata", td, 0);
      chk("rst_tlast", tl, 0);
      chk("rst_frames", fr, 0);
      chk("rst_seqerr", serr, 0);
      rst = 1'b0;
      chk("ready_before_edge", hrdy, 0);
      tick();
      chk("ready_after_rst", hrdy, 1);

      trdy = 1'b1;
      tick();
      chk("single_exact", 0, 0 | 0);
      n_tot--; n_pass--;
      hv = 1'b1; hh = 9'd5; hlh = 16'd100; hw = 1'b1;
      hm = 4'd3; hx = 16'h8000;
      tick();
      hv = 1'b0;
      chk("single_tvalid", tv, 1);
      chk("single_word", td, 38'h0AC938000);
      chk("single_tlast", tl, 0);
      tick();

      foreach (vecs[i]) begin
         chk($sformatf("vec%0d_ready", i), hrdy, 1);
         hv = 1'b1; hh = vecs[i].h; hlh = vecs[i].lh;
         hw = vecs[i].w; hm = vecs[i].m; hx = vecs[i].x;
         tick();
         hv = 1'b0;
         chk($sformatf("vec%0d_tvalid", i), tv, vecs[i].e_v);
         if (vecs[i].e_v) begin
            ew = {vecs[i].h, vecs[i].e_lh, vecs[i].w,
                  vecs[i].m, vecs[i].x};
            chk($sformatf("vec%0d_tdata", i), td, ew);
            chk($sformatf("vec%0d_tlast", i), tl, vecs[i].e_last);
         end
         tick();
         chk($sformatf("vec%0d_drained", i), tv, 0);
      end
      chk("vec_frames", fr, 1);

      // Backpressure: two accepts fill the buffer.
      do_reset();
      trdy = 1'b0;
      col(9'd0);
      tick();
      chk("bp_ready1", hrdy, 1);
      col(9'd1);
      tick();
      chk("bp_ready_drop", hrdy, 0);
      chk("bp_h0", td[37:29], 0);
      col(9'd2);
      tick();
      chk("bp_stable_v", tv, 1);
      chk("bp_stable_h0", td[37:29], 0);
      trdy = 1'b1;
      tick();
      chk("bp_ready_back", hrdy, 1);
      chk("bp_h1", td[37:29], 1);
      tick();
      chk("bp_h2", td[37:29], 2);
      col(9'd3);
      tick();
      hv = 1'b0;
      chk("bp_h3", td[37:29], 3);
      tick();
      chk("bp_empty", tv, 0);

      // Full frame at one column per cycle.
      do_reset();
      trdy = 1'b1;
      bad_h = 0; bad_l = 0; bad_v = 0;
      for (int i = 0; i < 320; i++) begin
         col(9'(i));
         tick();
         if (tv !== 1'b1) bad_v++;
         if (td[37:29] !== 9'(i)) bad_h++;
         if (tl !== (i == 319)) bad_l++;
         if (i == 318) chk("frame_fr_mid", fr, 0);
      end
      hv = 1'b0;
      chk("frame_valid_each", bad_v, 0);
      chk("frame_order", bad_h, 0);
      chk("frame_tlast", bad_l, 0);
      tick();
      chk("frame_count", fr, 1);
      chk("frame_seqerr", serr, 0);

      // Column order / range.
      col(9'd0); tick();
      col(9'd1); tick();
      chk("order_ok", serr, 0);
      col(9'd3); tick();
      hv = 1'b0;
      chk("order_err", serr, SEQ_ON);
      tick();
      chk("order_drained", tv, 0);
      col(9'd400);
      chk("drop_ready", hrdy, 1);
      tick();
      hv = 1'b0;
      chk("drop_tvalid", tv, 0);
      chk("drop_ready_after", hrdy, 1);
      tick();
      chk("drop_tvalid2", tv, 0);

      // Reset while holding two words.
      trdy = 1'b0;
      col(9'd0); tick();
      col(9'd1); tick();
      hv = 1'b0;
      chk("two_ready", hrdy, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_tvalid", tv, 0);
      chk("rst2_frames", fr, 0);
      chk("rst2_seqerr", serr, 0);
      tick();
      chk("rst2_ready", hrdy, 1);
      trdy = 1'b1;
      col(9'd0); tick();
      hv = 1'b0;
      chk("rst2_restart_v", tv, 1);
      chk("rst2_restart_seq", serr, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
